// File: rtl/cpu_defs_pkg.sv
// Shared opcode/funct encodings and instruction field positions for the
// MIPS-subset pipeline; used by the ID, EX and WB stages.
package cpu_defs;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_MSB = 15;
  localparam int unsigned RD_LSB = 11;
  localparam int unsigned FN_MSB = 5;
  localparam int unsigned FN_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  function automatic logic funct_writes_rd(input logic [5:0] funct);
    case (funct)
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
      F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA: funct_writes_rd = 1'b1;
      default:                            funct_writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_seg_decode.sv
// Combinational WB-stage instruction decode: write intent, data source and
// destination field select. JAL decode is gated by WB_JAL_EN.
module wb_decode
  import cpu_defs::*;
(
  input  logic [31:0] IR,
  output logic        we,
  output logic        sel_lmd,
  output logic        dst_is_rt,
  output logic        dst_is_r31
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = IR[OP_MSB:OP_LSB];
  assign funct  = IR[FN_MSB:FN_LSB];

  always_comb begin
    we         = 1'b0;
    sel_lmd    = 1'b0;
    dst_is_rt  = 1'b0;
    dst_is_r31 = 1'b0;
    case (opcode)
      OP_RTYPE: we = funct_writes_rd(funct);
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_SLTI, OP_SLTIU, OP_LUI: begin
        we        = 1'b1;
        dst_is_rt = 1'b1;
      end
      OP_LW: begin
        we        = 1'b1;
        sel_lmd   = 1'b1;
        dst_is_rt = 1'b1;
      end
`ifdef WB_JAL_EN
      OP_JAL: begin
        we         = 1'b1;
        dst_is_r31 = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_seg.sv
// Write-back stage: decodes the WB instruction and registers the register-file
// write port (data, index, enable). Optional JAL link write via WB_JAL_EN.
module wb_seg
  import cpu_defs::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     LMD_i,
  input  logic [DATA_W-1:0]     ALUo_i,
  input  logic [31:0]           IR_i,
  output logic [DATA_W-1:0]     WB_Data,
  output logic                  WB_Write,
  output logic [REG_ADDR_W-1:0] WB_Addr
);

  logic                  dec_we;
  logic                  dec_sel_lmd;
  logic                  dec_dst_is_rt;
  logic                  dec_dst_is_r31;
  logic [REG_ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0]     data_d;
  logic                  write_d;

  wb_decode u_decode (
    .IR         (IR_i),
    .we         (dec_we),
    .sel_lmd    (dec_sel_lmd),
    .dst_is_rt  (dec_dst_is_rt),
    .dst_is_r31 (dec_dst_is_r31)
  );

  always_comb begin
    addr_d = REG_ADDR_W'(IR_i[RD_MSB:RD_LSB]);
    if (dec_dst_is_r31)
      addr_d = REG_ADDR_W'(31);
    else if (dec_dst_is_rt)
      addr_d = REG_ADDR_W'(IR_i[RT_MSB:RT_LSB]);
    data_d  = dec_sel_lmd ? LMD_i : ALUo_i;
    // r0 is hardwired to zero, so a write to it is dropped here
    write_d = dec_we && (addr_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WB_Data  <= '0;
      WB_Write <= 1'b0;
      WB_Addr  <= '0;
    end else begin
      WB_Data  <= data_d;
      WB_Write <= write_d;
      WB_Addr  <= addr_d;
    end
  end

endmodule

// File: tb/tb_wb_seg.sv
// Scoreboard bench for wb_seg: expected write-port values are queued as each
// instruction is driven and compared one edge later.
module tb_wb_seg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [REG_ADDR_W-1:0] addr;
    logic                  write;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic [DATA_W-1:0]     LMD_i;
  logic [DATA_W-1:0]     ALUo_i;
  logic [31:0]           IR_i;
  logic [DATA_W-1:0]     WB_Data;
  logic                  WB_Write;
  logic [REG_ADDR_W-1:0] WB_Addr;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  wb_seg #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .LMD_i    (LMD_i),
    .ALUo_i   (ALUo_i),
    .IR_i     (IR_i),
    .WB_Data  (WB_Data),
    .WB_Write (WB_Write),
    .WB_Addr  (WB_Addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic rst_v, input logic [31:0] ir,
                                 input logic [31:0] lmd, input logic [31:0] alu);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    logic       r_ok, imm_ok, lw_ok, jal_ok;
    op     = ir[31:26];
    fn     = ir[5:0];
    r_ok   = (op == 6'o00) && (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                          6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03});
    imm_ok = op inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h0F};
    lw_ok  = (op == 6'h23);
`ifdef WB_JAL_EN
    jal_ok = (op == 6'h03);
`else
    jal_ok = 1'b0;
`endif
    e.addr  = jal_ok ? 5'd31 : ((imm_ok || lw_ok) ? ir[20:16] : ir[15:11]);
    e.data  = lw_ok ? lmd : alu;
    e.write = (r_ok || imm_ok || lw_ok || jal_ok) && (e.addr != 5'd0);
    if (!rst_v) e = '0;
    return e;
  endfunction

  // Drive one instruction at the falling edge, score it after the next rising edge.
  task automatic step(input string tag, input logic [31:0] ir,
                      input logic [31:0] lmd, input logic [31:0] alu);
    exp_t e;
    @(negedge clk);
    IR_i   = ir;
    LMD_i  = lmd;
    ALUo_i = alu;
    exp_q.push_back(model(rst, ir, lmd, alu));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"},  WB_Data,         e.data);
      check({tag, "_addr"},  32'(WB_Addr),    32'(e.addr));
      check({tag, "_write"}, 32'(WB_Write),   32'(e.write));
    end
  endtask

  localparam logic [5:0] OPS [16] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D,
                                      6'h0E, 6'h0A, 6'h0B, 6'h0F, 6'h23, 6'h2B,
                                      6'h04, 6'h05, 6'h02, 6'h03};

  initial begin
    logic [31:0] ir;
    logic [5:0]  op;
    rst    = 1'b0;
    IR_i   = '0;
    LMD_i  = '0;
    ALUo_i = '0;
    #1;
    check("reset_data",  WB_Data,        32'd0);
    check("reset_addr",  32'(WB_Addr),   32'd0);
    check("reset_write", 32'(WB_Write),  32'd0);

    step("rst_add",  32'h0109_5020, 32'd123, 32'd456);
    step("rst_lw",   32'h8D09_0000, 32'd123, 32'd456);
    step("rst_jal",  32'h0C00_0000, 32'd123, 32'd456);

    @(negedge clk);
    rst = 1'b1;
    step("add",      32'h0109_5020, 32'd123, 32'd456);
    step("addi",     32'h2128_0000, 32'd123, 32'd456);
    step("andi",     32'h3128_0000, 32'd123, 32'd456);
    step("lw",       32'h8D09_0000, 32'd123, 32'd456);
    step("sw",       32'hAD09_0000, 32'd123, 32'd456);
    step("nop",      32'h0000_0000, 32'd123, 32'd456);
    step("undef",    32'hA800_0000, 32'd123, 32'd456);
    step("r_rd0",    32'h0109_0020, 32'd123, 32'd456);
    step("jr",       32'h03E0_0008, 32'd123, 32'd456);
    step("sll",      32'h0009_5080, 32'd7,   32'd9);
    step("lw_rt0",   32'h8D00_0000, 32'd123, 32'd456);
    step("lui",      32'h3C1F_1234, 32'd1,   32'hDEAD_BEEF);
    step("beq",      32'h1109_0004, 32'd1,   32'd2);
    step("jal",      32'h0C00_0000, 32'd123, 32'd456);
    step("j",        32'h0800_0010, 32'd123, 32'd456);

    for (int unsigned i = 0; i < 40; i++) begin
      op = OPS[$urandom_range(0, 15)];
      ir = $urandom;
      ir[31:26] = op;
      if (op == 6'h00 && ($urandom_range(0, 1) == 1)) ir[5:0] = 6'h20 + 6'($urandom_range(0, 11));
      step("rand", ir, $urandom, $urandom);
    end

    // Asynchronous reset between edges with a write pending in the register
    step("pre_rst_add", 32'h0109_5020, 32'd123, 32'd456);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_data",  WB_Data,       32'd0);
    check("async_rst_addr",  32'(WB_Addr),  32'd0);
    check("async_rst_write", 32'(WB_Write), 32'd0);
    step("held_rst_lw", 32'h8D09_0000, 32'd123, 32'd456);
    rst = 1'b1;
    step("post_rst_add", 32'h0109_5020, 32'd11, 32'd22);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
